mem_access_ctrl: RTL and testbench

Multi-cycle memory-stage sequencer between the pipeline's memory stage and the data memory. It turns the decoder's LD/ST/STU controls (mem_to_reg, mem_write) into a request/response exchange with a variable-latency memory. It stalls the pipeline until the access completes, captures load data, and halts the machine on an unaligned access or a memory timeout.

---
 rtl/mem_access_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage sequencer between the pipeline and a
// variable-latency data memory. A LD/ST/STU held in the memory stage is turned
// into a request/response exchange. The pipeline is stalled until the access
// completes, load data is captured, and the machine halts on an unaligned
// access or a memory timeout.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   req_valid/write    memory-stage request and direction (1 = store)
//   req_addr/wdata     byte address and store data
//   stall              freeze pipeline stages at and before memory
//   rdata              registered load data
//   done               one-cycle completion pulse
//   err                sticky error (unaligned or timeout), cleared by rst
//   mem_en/wr          memory request strobe and direction
//   mem_addr/wdata     registered request address and write data
//   mem_busy           memory cannot accept the request this cycle
//   mem_done/rdata     memory completion pulse and read data
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        stall,
  output logic [15:0] rdata,
  output logic        done,
  output logic        err,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_busy,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [15:0]        rdata_q, rdata_d;
  logic               mem_wr_q, mem_wr_d;
  logic [15:0]        mem_addr_q, mem_addr_d;
  logic [15:0]        mem_wdata_q, mem_wdata_d;
  logic               stall_c;
  logic               done_c;
  logic               mem_en_c;
  logic               timeout_c;
  logic [CNT_W-1:0]   cnt_inc_c;

  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT));
  // Saturating increment used in ISSUE and WAIT.
  assign cnt_inc_c = timeout_c ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    stall_c     = 1'b0;
    done_c      = 1'b0;
    mem_en_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        stall_c = req_valid;
        if (req_valid) begin
          if (req_addr[0]) begin
            state_d = HALT;
            err_d   = 1'b1;
          end else begin
            mem_wr_d    = req_write;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
            cnt_d       = '0;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        stall_c  = 1'b1;
        mem_en_c = 1'b1;
        cnt_d    = cnt_inc_c;
        if (!mem_busy) begin
          state_d = WAIT;
        end else if (timeout_c) begin
          state_d = HALT;
          err_d   = 1'b1;
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_inc_c;
        // Completion is checked first so a mem_done on the timeout cycle wins.
        if (mem_done) begin
          if (!mem_wr_q) begin
            rdata_d = mem_rdata;
          end
          state_d = RESP;
        end else if (timeout_c) begin
          state_d = HALT;
          err_d   = 1'b1;
        end
      end
      RESP: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      HALT: begin
        stall_c = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // stall is gated by rst so a held req_valid cannot keep the pipeline frozen
  // while reset is asserted; the other strobes decode from the reset state.
  assign stall     = stall_c & ~rst;
  assign done      = done_c;
  assign mem_en    = mem_en_c;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: table of transactions driven against a reactive
// memory model, expected outcomes queued per transaction, plus hand-written
// sequences for halt stickiness and reset in the middle of an access.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        stall;
  logic [15:0] rdata;
  logic        done;
  logic        err;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_busy;
  logic        mem_done;
  logic [15:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  mem_access_ctrl #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .stall     (stall),
    .rdata     (rdata),
    .done      (done),
    .err       (err),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_busy  (mem_busy),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mrdata;     // data the memory model returns
    int          busy_n;     // cycles mem_busy is held while mem_en
    int          done_at;    // WAIT-cycle index of mem_done (large = never)
    int          exp_lat;    // cycle index of done or err, request cycle = 0
    int          exp_en;     // number of mem_en cycles
    logic        exp_err;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t tbl[12];
  vec_t sb[$];

  function automatic vec_t mk(input logic wr, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic [15:0] mrdata,
                              input int busy_n, input int done_at,
                              input int exp_lat, input int exp_en,
                              input logic exp_err, input logic [15:0] exp_rdata);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.mrdata = mrdata;
    v.busy_n = busy_n; v.done_at = done_at; v.exp_lat = exp_lat;
    v.exp_en = exp_en; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_state(input string nm);
    chk(nm, {stall, done, err, mem_en, mem_wr, rdata, mem_addr, mem_wdata}, 64'd0);
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    mem_busy  = 1'b0;
    mem_done  = 1'b0;
    rst       = 1'b1;
    #1;
    check_reset_state("reset_outputs");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one request and play the memory side until done or err appears.
  task automatic run_vec(input int idx, input vec_t v);
    int   en_cnt    = 0;
    int   wait_cnt  = 0;
    int   stall_cnt = 0;
    bit   acc       = 1'b0;
    bit   fin       = 1'b0;
    vec_t e;
    sb.push_back(v);
    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        mem_rdata = v.mrdata;
      end
      mem_busy = 1'b0;
      mem_done = 1'b0;
      if (mem_en) begin
        mem_busy = (en_cnt < v.busy_n);
        if (!mem_busy) acc = 1'b1;
        en_cnt++;
      end else if (acc) begin
        mem_done = (wait_cnt == v.done_at);
        wait_cnt++;
      end
      #1;
      if (mem_en && en_cnt == 1) begin
        chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr);
        chk($sformatf("v%0d_mem_wr", idx), mem_wr, v.wr);
        if (v.wr) chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.wdata);
      end
      if (done || err) begin
        e = sb.pop_front();
        chk($sformatf("v%0d_latency", idx), cyc, e.exp_lat);
        chk($sformatf("v%0d_err", idx), err, e.exp_err);
        chk($sformatf("v%0d_done", idx), done, !e.exp_err);
        chk($sformatf("v%0d_en_cycles", idx), en_cnt, e.exp_en);
        chk($sformatf("v%0d_stall_cycles", idx), stall_cnt, e.exp_lat);
        chk($sformatf("v%0d_stall_at_end", idx), stall, e.exp_err);
        chk($sformatf("v%0d_rdata", idx), rdata, e.exp_rdata);
        fin = 1'b1;
      end else if (stall) begin
        stall_cnt++;
      end
    end
    if (!fin) begin
      e = sb.pop_front();
      chk($sformatf("v%0d_no_completion", idx), 1, 0);
    end
    req_valid = 1'b0;
    mem_busy  = 1'b0;
    mem_done  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          wr    addr      wdata     mrdata    busy dn  lat en  err   rdata
    tbl[0]  = mk(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 0,  1,  4,  1,  1'b0, 16'hBEEF);
    tbl[1]  = mk(1'b1, 16'h0022, 16'h1234, 16'hDEAD, 3,  0,  6,  4,  1'b0, 16'hBEEF);
    tbl[2]  = mk(1'b0, 16'h0000, 16'h0000, 16'h1111, 0,  0,  3,  1,  1'b0, 16'h1111);
    tbl[3]  = mk(1'b0, 16'h0002, 16'h0000, 16'h2222, 0,  0,  3,  1,  1'b0, 16'h2222);
    tbl[4]  = mk(1'b0, 16'h0040, 16'h9999, 16'h0F0F, 2,  5,  10, 3,  1'b0, 16'h0F0F);
    tbl[5]  = mk(1'b0, 16'h0080, 16'h0000, 16'h5A5A, 0,  14, 17, 1,  1'b0, 16'h5A5A);
    tbl[6]  = mk(1'b1, 16'h0100, 16'hA5A5, 16'hDEAD, 1,  13, 17, 2,  1'b0, 16'h5A5A);
    tbl[7]  = mk(1'b0, 16'h0013, 16'h0000, 16'h3333, 0,  0,  1,  0,  1'b1, 16'h5A5A);
    tbl[8]  = mk(1'b1, 16'h0101, 16'h4444, 16'h3333, 0,  0,  1,  0,  1'b1, 16'h0000);
    tbl[9]  = mk(1'b0, 16'h0200, 16'h0000, 16'h6666, 0,  999, 17, 1, 1'b1, 16'h0000);
    tbl[10] = mk(1'b1, 16'h0300, 16'h7777, 16'h6666, 20, 0,  17, 16, 1'b1, 16'h0000);
    tbl[11] = mk(1'b0, 16'h0400, 16'h0000, 16'hCAFE, 0,  1,  4,  1,  1'b0, 16'hCAFE);

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    mem_busy = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    #1;
    check_reset_state("initial_reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_vec(i, tbl[i]);
      if (tbl[i].exp_err) begin
        // Halt must persist with no memory activity until reset.
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          #1;
          chk($sformatf("v%0d_halt_sticky", i), {err, stall, mem_en, done}, 4'b1100);
        end
        do_reset();
      end
    end

    // Reset asserted in the middle of WAIT, with a late mem_done afterwards.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0500; req_wdata = '0;
    mem_busy = 1'b0; mem_done = 1'b0; mem_rdata = 16'h7777;
    @(negedge clk); #1;
    chk("midrst_issue_en", mem_en, 1'b1);
    @(negedge clk); #1;
    chk("midrst_wait", {stall, mem_en}, 2'b10);
    @(negedge clk); #1;
    chk("midrst_wait2", {stall, mem_en, done}, 3'b100);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_async_drop", {stall, mem_en}, 2'b00);
    chk("midrst_rdata_cleared", rdata, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    mem_done = 1'b1;
    #1;
    chk("midrst_idle_stall", stall, 1'b0);
    @(negedge clk);
    mem_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("midrst_no_done", {done, err, mem_en, stall}, 4'b0000);
      chk("midrst_rdata", rdata, 16'h0000);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
